ibex_l2_rf_scheduler: RTL and testbench

Single-port access scheduler for the level-2 register-file SRAM (32x32) that sits behind the small flop-based level-1 register set.
- Serialises up to two operand-read misses per instruction and a stream of buffered write-backs onto the one SRAM port.
- Forwards pending write data to reads and asserts a pipeline stall while an instruction's misses are serviced.
- Sits between the register-file front end (L1 hit/miss logic) and the SRAM macro.

---
 rtl/ibex_l2_rf_scheduler_if.sv | 53 +++++
 rtl/ibex_l2_rf_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_ibex_l2_rf_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_l2_rf_scheduler_if.sv
// ============================================================================
// Module      : ibex_l2_rf_scheduler_if
// Description : Request/response, write-back and SRAM port bundle for the
//               level-2 register-file scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ibex_l2_rf_scheduler_if #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 5
);
   logic                 req_valid_i;
   logic                 req_ren_a_i;
   logic                 req_ren_b_i;
   logic [AddrWidth-1:0] req_raddr_a_i;
   logic [AddrWidth-1:0] req_raddr_b_i;
   logic                 req_ready_o;
   logic                 rsp_valid_o;
   logic [DataWidth-1:0] rsp_rdata_a_o;
   logic [DataWidth-1:0] rsp_rdata_b_o;
   logic                 wr_valid_i;
   logic [AddrWidth-1:0] wr_addr_i;
   logic [DataWidth-1:0] wr_data_i;
   logic                 wr_ready_o;
   logic [AddrWidth-1:0] sram_addr_o;
   logic                 sram_we_o;
   logic [DataWidth-1:0] sram_wdata_o;
   logic [DataWidth-1:0] sram_rdata_i;
   logic                 stall_o;

   modport slave (
      input  req_valid_i, req_ren_a_i, req_ren_b_i, req_raddr_a_i, req_raddr_b_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_a_o, rsp_rdata_b_o,
      input  wr_valid_i, wr_addr_i, wr_data_i,
      output wr_ready_o,
      output sram_addr_o, sram_we_o, sram_wdata_o,
      input  sram_rdata_i,
      output stall_o
   );

   modport master (
      output req_valid_i, req_ren_a_i, req_ren_b_i, req_raddr_a_i, req_raddr_b_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_a_o, rsp_rdata_b_o,
      output wr_valid_i, wr_addr_i, wr_data_i,
      input  wr_ready_o,
      input  sram_addr_o, sram_we_o, sram_wdata_o,
      output sram_rdata_i,
      input  stall_o
   );
endinterface

`default_nettype wire

// File: rtl/ibex_l2_rf_scheduler.sv
// ============================================================================
// Module      : ibex_l2_rf_scheduler
// Description : Single-port L2 register-file SRAM scheduler: serialises operand
//               read misses and buffered write-backs, forwards pending writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_l2_rf_scheduler #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 5,
   parameter int WbDepth   = 2
) (
   input  wire logic              clk_i,
   input  wire logic              rst_i,
   ibex_l2_rf_scheduler_if.slave  bus
);

   localparam int c_ptr_w = $clog2(WbDepth);
   localparam int c_cnt_w = c_ptr_w + 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_LAST = 3'd3,
      ST_RESP = 3'd4
   } state_e;

   state_e               r_state;
   logic                 r_en_b;
   logic [AddrWidth-1:0] r_addr_a;
   logic [AddrWidth-1:0] r_addr_b;
   logic [DataWidth-1:0] r_rdata_a;
   logic [DataWidth-1:0] r_rdata_b;
   logic                 r_rsp_valid;
   logic                 r_pend;
   logic                 r_pend_sel;

   logic [AddrWidth-1:0] r_wb_addr [WbDepth];
   logic [DataWidth-1:0] r_wb_data [WbDepth];
   logic [c_ptr_w-1:0]   r_wb_rd;
   logic [c_ptr_w-1:0]   r_wb_wr;
   logic [c_cnt_w-1:0]   r_wb_cnt;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_accept_wr;
   logic                 w_push;
   logic                 w_rd_slot;
   logic                 w_rd_issue;
   logic                 w_drain;
   logic [AddrWidth-1:0] w_rd_addr;
   logic                 w_fwd_hit;
   logic [DataWidth-1:0] w_fwd_data;
   logic [c_ptr_w-1:0]   w_idx;

   assign w_full      = (r_wb_cnt == c_cnt_w'(WbDepth));
   assign w_empty     = (r_wb_cnt == '0);
   assign w_accept_wr = bus.wr_valid_i && !w_full;
   assign w_push      = w_accept_wr && (bus.wr_addr_i != '0);
   assign w_rd_addr   = (r_state == ST_RD_B) ? r_addr_b : r_addr_a;
   // A full buffer steals the read slot so the drain can make room.
   assign w_rd_slot   = ((r_state == ST_RD_A) || (r_state == ST_RD_B)) && !w_full;
   assign w_rd_issue  = w_rd_slot && !w_fwd_hit;
   assign w_drain     = !w_empty && !w_rd_issue;

   // Oldest-to-youngest scan so the youngest match wins; an incoming write beats all.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      w_idx      = '0;
      for (int i = 0; i < WbDepth; i++) begin
         w_idx = r_wb_rd + c_ptr_w'(i);
         if ((c_cnt_w'(i) < r_wb_cnt) && (r_wb_addr[w_idx] == w_rd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_wb_data[w_idx];
         end
      end
      if (w_accept_wr && (bus.wr_addr_i == w_rd_addr)) begin
         w_fwd_hit  = 1'b1;
         w_fwd_data = bus.wr_data_i;
      end
   end

   always_comb begin
      bus.sram_addr_o  = '0;
      bus.sram_we_o    = 1'b0;
      bus.sram_wdata_o = '0;
      if (w_rd_issue) begin
         bus.sram_addr_o = w_rd_addr;
      end else if (w_drain) begin
         bus.sram_addr_o  = r_wb_addr[r_wb_rd];
         bus.sram_we_o    = 1'b1;
         bus.sram_wdata_o = r_wb_data[r_wb_rd];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_en_b      <= 1'b0;
         r_addr_a    <= '0;
         r_addr_b    <= '0;
         r_rdata_a   <= '0;
         r_rdata_b   <= '0;
         r_rsp_valid <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_sel  <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_wr     <= '0;
         r_wb_cnt    <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_pend      <= 1'b0;
         // SRAM data of last cycle's miss lands here regardless of the current state.
         if (r_pend) begin
            if (r_pend_sel) r_rdata_b <= bus.sram_rdata_i;
            else            r_rdata_a <= bus.sram_rdata_i;
         end

         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid_i) begin
                  r_en_b   <= bus.req_ren_b_i && (bus.req_raddr_b_i != '0);
                  r_addr_a <= bus.req_raddr_a_i;
                  r_addr_b <= bus.req_raddr_b_i;
                  if (bus.req_raddr_a_i == '0) r_rdata_a <= '0;
                  if (bus.req_raddr_b_i == '0) r_rdata_b <= '0;
                  if (bus.req_ren_a_i && (bus.req_raddr_a_i != '0))      r_state <= ST_RD_A;
                  else if (bus.req_ren_b_i && (bus.req_raddr_b_i != '0)) r_state <= ST_RD_B;
                  else                                                   r_state <= ST_LAST;
               end
            end
            ST_RD_A: begin
               if (w_rd_slot) begin
                  if (w_fwd_hit) begin
                     r_rdata_a <= w_fwd_data;
                  end else begin
                     r_pend     <= 1'b1;
                     r_pend_sel <= 1'b0;
                  end
                  r_state <= r_en_b ? ST_RD_B : ST_LAST;
               end
            end
            ST_RD_B: begin
               if (w_rd_slot) begin
                  if (w_fwd_hit) begin
                     r_rdata_b <= w_fwd_data;
                  end else begin
                     r_pend     <= 1'b1;
                     r_pend_sel <= 1'b1;
                  end
                  r_state <= ST_LAST;
               end
            end
            ST_LAST: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         if (w_push) begin
            r_wb_addr[r_wb_wr] <= bus.wr_addr_i;
            r_wb_data[r_wb_wr] <= bus.wr_data_i;
            r_wb_wr            <= r_wb_wr + 1'b1;
         end
         if (w_drain) begin
            r_wb_rd <= r_wb_rd + 1'b1;
         end
         r_wb_cnt <= r_wb_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_drain);
      end
   end

   assign bus.req_ready_o   = (r_state == ST_IDLE);
   assign bus.rsp_valid_o   = r_rsp_valid;
   assign bus.rsp_rdata_a_o = r_rdata_a;
   assign bus.rsp_rdata_b_o = r_rdata_b;
   assign bus.wr_ready_o    = !w_full;
   assign bus.stall_o       = ((r_state == ST_IDLE) && bus.req_valid_i) ||
                              (r_state == ST_RD_A) || (r_state == ST_RD_B) ||
                              (r_state == ST_LAST);

endmodule

`default_nettype wire

// File: tb/tb_ibex_l2_rf_scheduler.sv
// ============================================================================
// Module      : tb_ibex_l2_rf_scheduler
// Description : Directed and randomised bench for ibex_l2_rf_scheduler against
//               an architectural register-file model and an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_l2_rf_scheduler;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk_i = 1'b0;
   logic rst_i;

   ibex_l2_rf_scheduler_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

   ibex_l2_rf_scheduler #(.DataWidth(DW), .AddrWidth(AW), .WbDepth(2)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // SRAM macro model: synchronous write, read data one cycle after issue.
   logic [DW-1:0] mem [32];
   logic          wrote0 = 1'b0;
   always @(posedge clk_i) begin
      if (bus.sram_we_o) begin
         mem[bus.sram_addr_o] <= bus.sram_wdata_o;
         if (bus.sram_addr_o == '0) wrote0 <= 1'b1;
      end
      bus.sram_rdata_i <= mem[bus.sram_addr_o];
   end

   // Architectural register file: a register holds the last accepted write.
   logic [DW-1:0] arch [32];
   bit            ignore_wr = 1'b0;
   always @(posedge clk_i) begin
      if (!rst_i && !ignore_wr && bus.wr_valid_i && bus.wr_ready_o && bus.wr_addr_i != '0)
         arch[bus.wr_addr_i] <= bus.wr_data_i;
   end

   int            n_chk = 0;
   int            n_err = 0;
   logic [AW-1:0] log_addr [16];
   logic          log_we   [16];
   logic [DW-1:0] rsp_a, rsp_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic ok;
      ok = 1'b0;
      bus.wr_valid_i = 1'b1;
      bus.wr_addr_i  = a;
      bus.wr_data_i  = d;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk_i);
         ok = bus.wr_ready_o;
         cyc();
      end
      bus.wr_valid_i = 1'b0;
      chk("wr_accept", ok, 1);
   endtask

   // Holds the request until rsp_valid; up to two writes at chosen cycle offsets.
   task automatic run_req(input logic ea, input logic [AW-1:0] a,
                          input logic eb, input logic [AW-1:0] b,
                          input int w0_at, input logic [AW-1:0] w0_a, input logic [DW-1:0] w0_d,
                          input int w1_at, input logic [AW-1:0] w1_a, input logic [DW-1:0] w1_d,
                          output int lat, output int stalls);
      bit got;
      got    = 1'b0;
      lat    = -1;
      stalls = 0;
      bus.req_valid_i   = 1'b1;
      bus.req_ren_a_i   = ea;
      bus.req_ren_b_i   = eb;
      bus.req_raddr_a_i = a;
      bus.req_raddr_b_i = b;
      bus.wr_valid_i    = (w0_at == 0) || (w1_at == 0);
      bus.wr_addr_i     = (w0_at == 0) ? w0_a : w1_a;
      bus.wr_data_i     = (w0_at == 0) ? w0_d : w1_d;
      for (int c = 0; c < 16 && !got; c++) begin
         @(negedge clk_i);
         log_addr[c] = bus.sram_addr_o;
         log_we[c]   = bus.sram_we_o;
         if (bus.stall_o) stalls++;
         if (bus.rsp_valid_o) begin
            got   = 1'b1;
            lat   = c;
            rsp_a = bus.rsp_rdata_a_o;
            rsp_b = bus.rsp_rdata_b_o;
         end
         cyc();
         bus.wr_valid_i = (w0_at == c + 1) || (w1_at == c + 1);
         bus.wr_addr_i  = (w0_at == c + 1) ? w0_a : w1_a;
         bus.wr_data_i  = (w0_at == c + 1) ? w0_d : w1_d;
         if (got) bus.req_valid_i = 1'b0;
      end
      bus.req_valid_i = 1'b0;
      bus.wr_valid_i  = 1'b0;
      chk("rsp_seen", got, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int            lat, stalls, nread, nom, wmode, nmis;
   logic          ea, eb;
   logic [AW-1:0] a, b, wa;
   logic [DW-1:0] v7, v9, old30, wd;

   initial begin
      rst_i             = 1'b1;
      bus.req_valid_i   = 1'b0;
      bus.req_ren_a_i   = 1'b0;
      bus.req_ren_b_i   = 1'b0;
      bus.req_raddr_a_i = '0;
      bus.req_raddr_b_i = '0;
      bus.wr_valid_i    = 1'b0;
      bus.wr_addr_i     = '0;
      bus.wr_data_i     = '0;

      // Reset values, stall follows req_valid while idle
      cyc();
      bus.req_valid_i = 1'b1;
      @(negedge clk_i);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
      chk("rst_rdata_a", bus.rsp_rdata_a_o, 0);
      chk("rst_rdata_b", bus.rsp_rdata_b_o, 0);
      chk("rst_req_ready", bus.req_ready_o, 1);
      chk("rst_wr_ready", bus.wr_ready_o, 1);
      chk("rst_sram_we", bus.sram_we_o, 0);
      chk("rst_sram_addr", bus.sram_addr_o, 0);
      chk("rst_stall_hi", bus.stall_o, 1);
      cyc();
      rst_i = 1'b0;
      bus.req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("idle_stall_lo", bus.stall_o, 0);
      cyc();

      for (int r = 1; r < 32; r++) wr_one(5'(r), $urandom);
      wr_one(5'd3, 32'h11);
      wr_one(5'd20, 32'h22);
      repeat (3) cyc();

      // Two SRAM misses
      run_req(1, 5'd3, 1, 5'd20, -1, 0, 0, -1, 0, 0, lat, stalls);
      chk("two_lat", lat, 4);
      chk("two_stalls", stalls, 4);
      chk("two_rd_a", rsp_a, 32'h11);
      chk("two_rd_b", rsp_b, 32'h22);
      chk("two_sram_t1", {log_we[1], log_addr[1]}, {1'b0, 5'd3});
      chk("two_sram_t2", {log_we[2], log_addr[2]}, {1'b0, 5'd20});
      repeat (2) cyc();

      // Forward from the write buffer
      run_req(1, 5'd5, 0, 5'd0, 0, 5'd5, 32'hAB, -1, 0, 0, lat, stalls);
      nread = 0;
      for (int c = 0; c <= lat && c < 16; c++) if (!log_we[c] && log_addr[c] == 5'd5) nread++;
      chk("fwd_buf_lat", lat, 3);
      chk("fwd_buf_data", rsp_a, 32'hAB);
      chk("fwd_buf_b_zero", rsp_b, 0);
      chk("fwd_buf_noread", nread, 0);
      repeat (2) cyc();

      // Forward from a write arriving in the read-issue cycle
      run_req(1, 5'd5, 0, 5'd0, 1, 5'd5, 32'hCD, -1, 0, 0, lat, stalls);
      nread = 0;
      for (int c = 0; c <= lat && c < 16; c++) if (!log_we[c] && log_addr[c] == 5'd5) nread++;
      chk("fwd_in_lat", lat, 3);
      chk("fwd_in_data", rsp_a, 32'hCD);
      chk("fwd_in_noread", nread, 0);
      repeat (2) cyc();

      // Buffer fills during the request; B read blocked one cycle by a drain of reg 7
      v7 = $urandom;
      v9 = $urandom;
      run_req(1, 5'd20, 1, 5'd7, 0, 5'd7, v7, 1, 5'd9, v9, lat, stalls);
      chk("full_lat", lat, 5);
      chk("full_stalls", stalls, 5);
      chk("full_drain", {log_we[2], log_addr[2]}, {1'b1, 5'd7});
      chk("full_read", {log_we[3], log_addr[3]}, {1'b0, 5'd7});
      chk("full_rd_a", rsp_a, 32'h22);
      chk("full_rd_b", rsp_b, v7);
      repeat (3) cyc();

      // Zero address
      run_req(1, 5'd0, 0, 5'd0, -1, 0, 0, -1, 0, 0, lat, stalls);
      chk("zero_lat", lat, 2);
      chk("zero_rd_a", rsp_a, 0);
      chk("zero_rd_b", rsp_b, 0);
      wr_one(5'd0, 32'hDEADBEEF);
      repeat (3) cyc();

      // Reset in RD_B with one buffered write
      ignore_wr = 1'b1;
      old30 = arch[30];
      bus.req_valid_i   = 1'b1;
      bus.req_ren_a_i   = 1'b1;
      bus.req_ren_b_i   = 1'b1;
      bus.req_raddr_a_i = 5'd3;
      bus.req_raddr_b_i = 5'd20;
      cyc();
      bus.wr_valid_i = 1'b1;
      bus.wr_addr_i  = 5'd30;
      bus.wr_data_i  = ~old30;
      cyc();
      bus.wr_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mid_rd_b_stall", bus.stall_o, 1);
      cyc();
      rst_i = 1'b0;
      bus.req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("mid_stall", bus.stall_o, 0);
      chk("mid_wr_ready", bus.wr_ready_o, 1);
      chk("mid_req_ready", bus.req_ready_o, 1);
      chk("mid_sram_we", bus.sram_we_o, 0);
      repeat (5) cyc();
      chk("mid_dropped", mem[30], old30);
      ignore_wr = 1'b0;

      // Randomised requests with interleaved write-backs
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 2)) wr_one(5'($urandom_range(0, 31)), $urandom);
         ea = 1'($urandom_range(0, 1));
         eb = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         b  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wmode = $urandom_range(0, 3);
         wa = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? b : 5'($urandom_range(0, 31)));
         wd = $urandom;
         run_req(ea, a, eb, b,
                 (wmode[0] ? 0 : -1), wa, wd,
                 (wmode[1] ? 1 : -1), ($urandom_range(0, 1) == 0) ? b : a, $urandom,
                 lat, stalls);
         if (a == '0)  chk("rnd_a_zero", rsp_a, 0);
         else if (ea)  chk("rnd_a", rsp_a, arch[a]);
         if (b == '0)  chk("rnd_b_zero", rsp_b, 0);
         else if (eb)  chk("rnd_b", rsp_b, arch[b]);
         nom = 2 + int'(ea && a != '0) + int'(eb && b != '0);
         chk("rnd_lat", (lat >= nom) && (lat <= nom + 1), 1);
         chk("rnd_stall_len", stalls, lat);
      end

      // Everything accepted must have drained; nothing to register 0
      repeat (5) cyc();
      nmis = 0;
      for (int r = 1; r < 32; r++) if (mem[r] !== arch[r]) nmis++;
      chk("final_mem", nmis, 0);
      chk("sram_wr0", wrote0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
